// File: rtl/asic_cfg_pkg.sv
// Shared types and constants for the ASIC configuration scheduler
// and the serial configuration shifter it drives.
package asic_cfg_pkg;

  localparam int DEF_SIZESRSTAT = 88;
  localparam int DEF_SIZESRDYN  = 16;

  localparam logic GRANT_STAT = 1'b1;
  localparam logic GRANT_DYN  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_WAIT_END,
    ST_RELEASE,
    ST_ACK
  } state_t;

endpackage

// File: rtl/asic_config_scheduler_cdc_sync_bit.sv
// Reset-to-zero flop chain bringing one asynchronous level into the
// local clock domain.
module cdc_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/asic_config_scheduler.sv
// Arbitrates static/dynamic configuration requests and sequences the
// 2 MHz configuration shifter handshake with a per-transfer timeout.
module asic_config_scheduler
  import asic_cfg_pkg::*;
#(
  parameter int SIZESRSTAT     = DEF_SIZESRSTAT,
  parameter int SIZESRDYN      = DEF_SIZESRDYN,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  stat_req,
  input  logic [SIZESRSTAT-1:0] stat_data,
  output logic                  stat_ack,
  input  logic                  dyn_req,
  input  logic [SIZESRDYN-1:0]  dyn_data,
  output logic                  dyn_ack,
  output logic [SIZESRSTAT-1:0] static_conf_ear,
  output logic [SIZESRDYN-1:0]  dynamic_conf,
  output logic                  flag_stat,
  output logic                  flag_dyn,
  output logic                  start_ASIC_config,
  input  logic                  end_config,
  output logic                  busy,
  output logic                  static_done,
  output logic                  err_timeout
);

  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  logic                  r_sel_stat;
  logic                  r_last_stat;
  logic [CW-1:0]         r_cnt;
  logic [SIZESRSTAT-1:0] r_stat_word;
  logic [SIZESRDYN-1:0]  r_dyn_word;
  logic                  r_flag_stat;
  logic                  r_flag_dyn;
  logic                  r_start;
  logic                  r_stat_ack;
  logic                  r_dyn_ack;
  logic                  r_busy;
  logic                  r_static_done;
  logic                  r_err;

  logic w_end_sync;
  logic w_dyn_elig;
  logic w_any_req;
  logic w_grant_stat;
  logic w_to;
  logic w_cnt_run;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_end_sync (
    .i_clk(CLK),
    .i_rst(RST),
    .i_d  (end_config),
    .o_q  (w_end_sync)
  );

  // Dynamic words are meaningless until the static word is in place.
  assign w_dyn_elig   = dyn_req & r_static_done;
  assign w_any_req    = stat_req | w_dyn_elig;
  assign w_grant_stat = stat_req & ~(w_dyn_elig & r_last_stat);
  assign w_to         = (r_cnt == TO_LAST);
  assign w_cnt_run    = (r_state == ST_ARM)
                      | (r_state == ST_WAIT_END)
                      | (r_state == ST_RELEASE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_sel_stat    <= GRANT_DYN;
      r_last_stat   <= 1'b0;
      r_cnt         <= '0;
      r_stat_word   <= '0;
      r_dyn_word    <= '0;
      r_flag_stat   <= 1'b0;
      r_flag_dyn    <= 1'b0;
      r_start       <= 1'b0;
      r_stat_ack    <= 1'b0;
      r_dyn_ack     <= 1'b0;
      r_busy        <= 1'b0;
      r_static_done <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_stat_ack <= 1'b0;
      r_dyn_ack  <= 1'b0;
      // Hold at the last count so the abort condition stays visible.
      if (w_cnt_run && !w_to) begin
        r_cnt <= r_cnt + 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state    <= ST_LOAD;
            r_sel_stat <= w_grant_stat;
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            if (w_grant_stat) begin
              r_stat_word <= stat_data;
            end else begin
              r_dyn_word <= dyn_data;
            end
          end
        end
        ST_LOAD: begin
          r_state     <= ST_ARM;
          r_flag_stat <= r_sel_stat;
          r_flag_dyn  <= ~r_sel_stat;
        end
        ST_ARM, ST_WAIT_END: begin
          if (w_to) begin
            r_state     <= ST_RELEASE;
            r_err       <= 1'b1;
            r_flag_stat <= 1'b0;
            r_flag_dyn  <= 1'b0;
            r_start     <= 1'b1;
          end else if (r_state == ST_ARM) begin
            r_state <= ST_WAIT_END;
          end else if (w_end_sync) begin
            r_state     <= ST_RELEASE;
            r_flag_stat <= 1'b0;
            r_flag_dyn  <= 1'b0;
            r_start     <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (w_to || !w_end_sync) begin
            r_state       <= ST_ACK;
            r_start       <= 1'b0;
            r_err         <= r_err | w_to;
            r_stat_ack    <= r_sel_stat;
            r_dyn_ack     <= ~r_sel_stat;
            r_last_stat   <= ~r_last_stat;
            r_static_done <= r_static_done
                           | (r_sel_stat & ~r_err & ~w_to);
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign static_conf_ear   = r_stat_word;
  assign dynamic_conf      = r_dyn_word;
  assign flag_stat         = r_flag_stat;
  assign flag_dyn          = r_flag_dyn;
  assign start_ASIC_config = r_start;
  assign stat_ack          = r_stat_ack;
  assign dyn_ack           = r_dyn_ack;
  assign busy              = r_busy;
  assign static_done       = r_static_done;
  assign err_timeout       = r_err;

endmodule
